// File: rtl/sna_response_packetizer_if.sv
// rtl/sna_response_packetizer_if.sv - handshake bundle for the SNA response packetizer
interface sna_response_packetizer_if;
    // return-context push from the SNA request flow
    logic        ctx_push;
    logic        ctx_is_read;
    logic [3:0]  ctx_src;
    logic [2:0]  ctx_vc;
    logic        ctx_rd_full;
    logic        ctx_wr_full;

    // AXI4-Lite slave R/B channels
    logic        s_rvalid;
    logic [31:0] s_rdata;
    logic [1:0]  s_rresp;
    logic        s_rready;
    logic        s_bvalid;
    logic [1:0]  s_bresp;
    logic        s_bready;

    // flits towards the response sender
    logic [36:0] header;
    logic [36:0] tail;
    logic        rvalid;
    logic        bvalid;
    logic        rready;
    logic        bready;

    modport slave (
        input  ctx_push, ctx_is_read, ctx_src, ctx_vc,
        input  s_rvalid, s_rdata, s_rresp, s_bvalid, s_bresp,
        input  rready, bready,
        output ctx_rd_full, ctx_wr_full, s_rready, s_bready,
        output header, tail, rvalid, bvalid
    );

    modport master (
        output ctx_push, ctx_is_read, ctx_src, ctx_vc,
        output s_rvalid, s_rdata, s_rresp, s_bvalid, s_bresp,
        output rready, bready,
        input  ctx_rd_full, ctx_wr_full, s_rready, s_bready,
        input  header, tail, rvalid, bvalid
    );
endinterface

// File: rtl/sna_response_packetizer.sv
// rtl/sna_response_packetizer.sv - AXI R/B response to NoC header/tail flit packetizer (optional SNA_RESP_PKT_ERRCNT_EN error counter)
module sna_response_packetizer #(
    parameter logic [3:0] NODE_ID   = 4'd0,
    parameter int         CTX_DEPTH = 4
) (
    input  logic clock,
    input  logic reset_n,
    sna_response_packetizer_if.slave bus
`ifdef SNA_RESP_PKT_ERRCNT_EN
    ,
    output logic [7:0] err_count
`endif
);
    localparam int AW = (CTX_DEPTH > 1) ? $clog2(CTX_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(CTX_DEPTH);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD_R = 2'd1,
        HOLD_B = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_next_state;

    // context entries are {vc[2:0], src[3:0]}
    logic [6:0]    r_rd_mem [CTX_DEPTH];
    logic [AW-1:0] r_rd_wptr;
    logic [AW-1:0] r_rd_rptr;
    logic [CW-1:0] r_rd_cnt;
    logic [6:0]    r_wr_mem [CTX_DEPTH];
    logic [AW-1:0] r_wr_wptr;
    logic [AW-1:0] r_wr_rptr;
    logic [CW-1:0] r_wr_cnt;

    logic [36:0]   r_header;
    logic [36:0]   r_tail;
    logic [4:0]    r_seq;

    logic          w_rd_full;
    logic          w_rd_empty;
    logic          w_wr_full;
    logic          w_wr_empty;
    logic          w_rd_push;
    logic          w_wr_push;
    logic [6:0]    w_rd_head;
    logic [6:0]    w_wr_head;
    logic          w_cap_r;
    logic          w_cap_b;
    logic          w_s_rready;
    logic          w_s_bready;

    assign w_rd_full  = (r_rd_cnt == DEPTH_C);
    assign w_rd_empty = (r_rd_cnt == '0);
    assign w_wr_full  = (r_wr_cnt == DEPTH_C);
    assign w_wr_empty = (r_wr_cnt == '0);

    // a push into a full FIFO is dropped, even if that FIFO pops in the same cycle
    assign w_rd_push  = bus.ctx_push &  bus.ctx_is_read & ~w_rd_full;
    assign w_wr_push  = bus.ctx_push & ~bus.ctx_is_read & ~w_wr_full;

    assign w_rd_head  = r_rd_mem[r_rd_rptr];
    assign w_wr_head  = r_wr_mem[r_wr_rptr];

    // context storage: data only, validity is carried by the pointers and counts
    always_ff @(posedge clock) begin
        if (w_rd_push) r_rd_mem[r_rd_wptr] <= {bus.ctx_vc, bus.ctx_src};
        if (w_wr_push) r_wr_mem[r_wr_wptr] <= {bus.ctx_vc, bus.ctx_src};
    end

    // read context FIFO pointers and occupancy; pops happen on read capture
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_wptr <= '0;
            r_rd_rptr <= '0;
            r_rd_cnt  <= '0;
        end else begin
            if (w_rd_push) r_rd_wptr <= r_rd_wptr + 1'b1;
            if (w_cap_r)   r_rd_rptr <= r_rd_rptr + 1'b1;
            case ({w_rd_push, w_cap_r})
                2'b10:   r_rd_cnt <= r_rd_cnt + 1'b1;
                2'b01:   r_rd_cnt <= r_rd_cnt - 1'b1;
                default: r_rd_cnt <= r_rd_cnt;
            endcase
        end
    end

    // write context FIFO pointers and occupancy; pops happen on write capture
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_wptr <= '0;
            r_wr_rptr <= '0;
            r_wr_cnt  <= '0;
        end else begin
            if (w_wr_push) r_wr_wptr <= r_wr_wptr + 1'b1;
            if (w_cap_b)   r_wr_rptr <= r_wr_rptr + 1'b1;
            case ({w_wr_push, w_cap_b})
                2'b10:   r_wr_cnt <= r_wr_cnt + 1'b1;
                2'b01:   r_wr_cnt <= r_wr_cnt - 1'b1;
                default: r_wr_cnt <= r_wr_cnt;
            endcase
        end
    end

    // FSM state register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) r_state <= IDLE;
        else          r_state <= w_next_state;
    end

    // FSM next state, AXI readies and capture strobes; R has priority over B
    always_comb begin
        w_next_state = r_state;
        w_s_rready   = 1'b0;
        w_s_bready   = 1'b0;
        w_cap_r      = 1'b0;
        w_cap_b      = 1'b0;
        case (r_state)
            IDLE: begin
                w_s_rready = ~w_rd_empty;
                // B must not handshake in a cycle where R is being taken
                w_s_bready = ~w_wr_empty & ~(bus.s_rvalid & ~w_rd_empty);
                if (bus.s_rvalid && w_s_rready) begin
                    w_cap_r      = 1'b1;
                    w_next_state = HOLD_R;
                end else if (bus.s_bvalid && w_s_bready) begin
                    w_cap_b      = 1'b1;
                    w_next_state = HOLD_B;
                end
            end
            HOLD_R: if (bus.rready) w_next_state = IDLE;
            HOLD_B: if (bus.bready) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // flit holding registers and sequence number, loaded on capture and held through HOLD
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_header <= '0;
            r_tail   <= '0;
            r_seq    <= '0;
        end else begin
            if (w_cap_r) begin
                r_header <= {2'b01, w_rd_head[6:4], w_rd_head[3:0], NODE_ID,
                             1'b1, bus.s_rresp, r_seq, 16'h0000};
                r_tail   <= {2'b10, w_rd_head[6:4], bus.s_rdata};
            end else if (w_cap_b) begin
                r_header <= {2'b01, w_wr_head[6:4], w_wr_head[3:0], NODE_ID,
                             1'b0, bus.s_bresp, r_seq, 16'h0000};
                r_tail   <= {2'b10, w_wr_head[6:4], 30'd0, bus.s_bresp};
            end
            if (w_cap_r || w_cap_b) r_seq <= r_seq + 5'd1;
        end
    end

`ifdef SNA_RESP_PKT_ERRCNT_EN
    logic [7:0] r_err_cnt;
    logic [1:0] w_cap_resp;

    assign w_cap_resp = w_cap_r ? bus.s_rresp : bus.s_bresp;

    // saturating count of captured non-OKAY responses
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_err_cnt <= '0;
        end else if ((w_cap_r || w_cap_b) && (w_cap_resp != 2'b00) && (r_err_cnt != 8'hFF)) begin
            r_err_cnt <= r_err_cnt + 8'd1;
        end
    end

    assign err_count = r_err_cnt;
`endif

    assign bus.ctx_rd_full = w_rd_full;
    assign bus.ctx_wr_full = w_wr_full;
    assign bus.s_rready    = w_s_rready;
    assign bus.s_bready    = w_s_bready;
    assign bus.header      = r_header;
    assign bus.tail        = r_tail;
    assign bus.rvalid      = (r_state == HOLD_R);
    assign bus.bvalid      = (r_state == HOLD_B);
endmodule

// File: tb/tb_sna_response_packetizer.sv
// tb/tb_sna_response_packetizer.sv - self-checking bench for sna_response_packetizer
module tb_sna_response_packetizer;
    localparam logic [3:0] NODE  = 4'd5;
    localparam int         DEPTH = 4;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    sna_response_packetizer_if bus();
`ifdef SNA_RESP_PKT_ERRCNT_EN
    logic [7:0] err_count;
`endif

    sna_response_packetizer #(.NODE_ID(NODE), .CTX_DEPTH(DEPTH)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
`ifdef SNA_RESP_PKT_ERRCNT_EN
        ,
        .err_count (err_count)
`endif
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // reference model: in-order context queues of {vc,src}, sequence and error tallies
    logic [6:0] q_rd[$];
    logic [6:0] q_wr[$];
    int         m_seq;
    int         m_err;

    function automatic logic [36:0] exp_header(input logic [2:0] vc, input logic [3:0] src,
                                               input bit rd, input logic [1:0] resp, input int seq);
        logic [36:0] h;
        h = 37'd1 << 35;
        h = h + (37'(vc) << 32) + (37'(src) << 28) + (37'(NODE) << 24);
        h = h + (37'(rd) << 23) + (37'(resp) << 21) + (37'(seq % 32) << 16);
        return h;
    endfunction

    function automatic logic [36:0] exp_tail(input logic [2:0] vc, input bit rd,
                                             input logic [31:0] data, input logic [1:0] resp);
        logic [36:0] t;
        t = (37'd2 << 35) + (37'(vc) << 32);
        t = t + (rd ? 37'(data) : 37'(resp));
        return t;
    endfunction

    function automatic int sat255(input int v);
        return (v > 255) ? 255 : v;
    endfunction

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs;
        bus.ctx_push = 0; bus.ctx_is_read = 0; bus.ctx_src = 0; bus.ctx_vc = 0;
        bus.s_rvalid = 0; bus.s_rdata = 0; bus.s_rresp = 0;
        bus.s_bvalid = 0; bus.s_bresp = 0;
        bus.rready = 0; bus.bready = 0;
    endtask

    task automatic do_reset;
        clear_inputs();
        reset_n = 0;
        repeat (2) tick();
        reset_n = 1;
        tick();
        q_rd.delete(); q_wr.delete();
        m_seq = 0; m_err = 0;
    endtask

    task automatic push_ctx(input bit rd, input logic [3:0] src, input logic [2:0] vc);
        bus.ctx_push = 1; bus.ctx_is_read = rd; bus.ctx_src = src; bus.ctx_vc = vc;
        if (rd) begin
            if (q_rd.size() < DEPTH) q_rd.push_back({vc, src});
        end else begin
            if (q_wr.size() < DEPTH) q_wr.push_back({vc, src});
        end
        tick();
        bus.ctx_push = 0;
    endtask

    // presents one response and waits (bounded) for the packet valid; no checking here
    task automatic drive_resp(input bit rd, input logic [31:0] data, input logic [1:0] resp, output bit got);
        got = 0;
        if (rd) begin bus.s_rvalid = 1; bus.s_rdata = data; bus.s_rresp = resp; end
        else    begin bus.s_bvalid = 1; bus.s_bresp = resp; end
        for (int i = 0; i < 4; i++) begin
            tick();
            if (rd ? bus.rvalid : bus.bvalid) begin got = 1; break; end
        end
        bus.s_rvalid = 0; bus.s_bvalid = 0;
    endtask

    task automatic release_pkt(input bit rd);
        if (rd) bus.rready = 1; else bus.bready = 1;
        tick();
        bus.rready = 0; bus.bready = 0;
    endtask

    task automatic test_reset;
        clear_inputs();
        reset_n = 0;
        repeat (2) tick();
        n_cmp++; if (bus.header !== 37'd0) begin n_fail++; $display("FAIL reset_header: got %h want 0", bus.header); end
        n_cmp++; if (bus.tail !== 37'd0) begin n_fail++; $display("FAIL reset_tail: got %h want 0", bus.tail); end
        n_cmp++; if ({bus.rvalid, bus.bvalid} !== 2'b00) begin n_fail++; $display("FAIL reset_valids: got %b want 00", {bus.rvalid, bus.bvalid}); end
        n_cmp++; if ({bus.ctx_rd_full, bus.ctx_wr_full} !== 2'b00) begin n_fail++; $display("FAIL reset_full: got %b want 00", {bus.ctx_rd_full, bus.ctx_wr_full}); end
        bus.s_rvalid = 1; bus.s_bvalid = 1;
        #1;
        n_cmp++; if ({bus.s_rready, bus.s_bready} !== 2'b00) begin n_fail++; $display("FAIL reset_readies: got %b want 00", {bus.s_rready, bus.s_bready}); end
        reset_n = 1;
        repeat (2) tick();
        n_cmp++; if ({bus.s_rready, bus.s_bready, bus.rvalid, bus.bvalid} !== 4'b0000) begin n_fail++; $display("FAIL post_reset_no_ctx: got %b want 0000", {bus.s_rready, bus.s_bready, bus.rvalid, bus.bvalid}); end
        clear_inputs();
        q_rd.delete(); q_wr.delete();
        m_seq = 0; m_err = 0;
    endtask

    task automatic test_read_basic;
        bit got;
        logic [36:0] want_h;
        do_reset();
        push_ctx(1, 4'd3, 3'd2);
        bus.s_rvalid = 1;
        #1;
        n_cmp++; if (bus.s_rready !== 1'b1) begin n_fail++; $display("FAIL rd_basic_s_rready: got %b want 1", bus.s_rready); end
        drive_resp(1, 32'hDEADBEEF, 2'b00, got);
        want_h = 37'h0A_3500_0000 | (37'd1 << 23);
        n_cmp++; if (got !== 1'b1) begin n_fail++; $display("FAIL rd_basic_rvalid: got %b want 1", got); end
        n_cmp++; if (bus.header !== want_h) begin n_fail++; $display("FAIL rd_basic_header: got %h want %h", bus.header, want_h); end
        n_cmp++; if (bus.tail !== {2'b10, 3'd2, 32'hDEADBEEF}) begin n_fail++; $display("FAIL rd_basic_tail: got %h want %h", bus.tail, {2'b10, 3'd2, 32'hDEADBEEF}); end
        n_cmp++; if ({bus.s_rready, bus.s_bready} !== 2'b00) begin n_fail++; $display("FAIL rd_basic_hold_readies: got %b want 00", {bus.s_rready, bus.s_bready}); end
        void'(q_rd.pop_front()); m_seq++;
        release_pkt(1);
        n_cmp++; if (bus.rvalid !== 1'b0) begin n_fail++; $display("FAIL rd_basic_release: got %b want 0", bus.rvalid); end
    endtask

    task automatic test_b_stall;
        logic [6:0] e;
        bus.s_bvalid = 1; bus.s_bresp = 2'b01;
        for (int i = 0; i < 10; i++) begin
            tick();
            n_cmp++; if ({bus.s_bready, bus.bvalid} !== 2'b00) begin n_fail++; $display("FAIL b_stall_cycle%0d: got %b want 00", i, {bus.s_bready, bus.bvalid}); end
        end
        push_ctx(0, 4'd7, 3'd5);
        n_cmp++; if (bus.s_bready !== 1'b1) begin n_fail++; $display("FAIL b_stall_ready_after_push: got %b want 1", bus.s_bready); end
        tick();
        bus.s_bvalid = 0;
        e = q_wr.pop_front();
        n_cmp++; if (bus.bvalid !== 1'b1) begin n_fail++; $display("FAIL b_stall_bvalid: got %b want 1", bus.bvalid); end
        n_cmp++; if (bus.tail[1:0] !== 2'b01) begin n_fail++; $display("FAIL b_stall_tail_bresp: got %b want 01", bus.tail[1:0]); end
        n_cmp++; if (bus.header !== exp_header(e[6:4], e[3:0], 0, 2'b01, m_seq)) begin n_fail++; $display("FAIL b_stall_header: got %h want %h", bus.header, exp_header(e[6:4], e[3:0], 0, 2'b01, m_seq)); end
        m_seq++;
        release_pkt(0);
    endtask

    task automatic test_priority;
        bit got;
        logic [6:0] e;
        do_reset();
        push_ctx(1, 4'd9, 3'd1);
        push_ctx(0, 4'd4, 3'd6);
        bus.s_rvalid = 1; bus.s_rdata = 32'hA5A5_0F0F; bus.s_rresp = 2'b00;
        bus.s_bvalid = 1; bus.s_bresp = 2'b11;
        #1;
        n_cmp++; if ({bus.s_rready, bus.s_bready} !== 2'b10) begin n_fail++; $display("FAIL prio_readies: got %b want 10", {bus.s_rready, bus.s_bready}); end
        tick();
        bus.s_rvalid = 0;
        e = q_rd.pop_front();
        n_cmp++; if ({bus.rvalid, bus.bvalid} !== 2'b10) begin n_fail++; $display("FAIL prio_r_first: got %b want 10", {bus.rvalid, bus.bvalid}); end
        n_cmp++; if (bus.header !== exp_header(e[6:4], e[3:0], 1, 2'b00, 0)) begin n_fail++; $display("FAIL prio_r_header_seq0: got %h want %h", bus.header, exp_header(e[6:4], e[3:0], 1, 2'b00, 0)); end
        tick();
        n_cmp++; if (bus.bvalid !== 1'b0) begin n_fail++; $display("FAIL prio_b_pending: got %b want 0", bus.bvalid); end
        release_pkt(1);
        n_cmp++; if ({bus.rvalid, bus.bvalid} !== 2'b00) begin n_fail++; $display("FAIL prio_no_back_to_back: got %b want 00", {bus.rvalid, bus.bvalid}); end
        n_cmp++; if (bus.s_bready !== 1'b1) begin n_fail++; $display("FAIL prio_b_ready_idle: got %b want 1", bus.s_bready); end
        tick();
        bus.s_bvalid = 0;
        e = q_wr.pop_front();
        n_cmp++; if (bus.bvalid !== 1'b1) begin n_fail++; $display("FAIL prio_b_captured: got %b want 1", bus.bvalid); end
        n_cmp++; if (bus.header !== exp_header(e[6:4], e[3:0], 0, 2'b11, 1)) begin n_fail++; $display("FAIL prio_b_header_seq1: got %h want %h", bus.header, exp_header(e[6:4], e[3:0], 0, 2'b11, 1)); end
        release_pkt(0);
        push_ctx(1, 4'd2, 3'd3);
        drive_resp(1, 32'h1234_5678, 2'b00, got);
        n_cmp++; if (bus.header[20:16] !== 5'd2) begin n_fail++; $display("FAIL prio_seq2: got %0d want 2", bus.header[20:16]); end
        void'(q_rd.pop_front());
        m_seq = 3; m_err = 1;
        release_pkt(1);
    endtask

    task automatic test_full;
        bit got;
        logic [6:0] e;
        logic [31:0] d;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            push_ctx(1, 4'(i + 1), 3'(i));
            n_cmp++; if (bus.ctx_rd_full !== (i >= 3)) begin n_fail++; $display("FAIL full_flag_push%0d: got %b want %b", i, bus.ctx_rd_full, (i >= 3)); end
        end
        n_cmp++; if (bus.ctx_wr_full !== 1'b0) begin n_fail++; $display("FAIL full_wr_flag: got %b want 0", bus.ctx_wr_full); end
        for (int k = 0; k < 5; k++) begin
            d = $urandom;
            drive_resp(1, d, 2'b00, got);
            n_cmp++; if (got !== (k < 4)) begin n_fail++; $display("FAIL full_accept%0d: got %b want %b", k, got, (k < 4)); end
            if (got) begin
                if (q_rd.size() > 0) begin
                    e = q_rd.pop_front();
                    n_cmp++; if (bus.header !== exp_header(e[6:4], e[3:0], 1, 2'b00, m_seq)) begin n_fail++; $display("FAIL full_header%0d: got %h want %h", k, bus.header, exp_header(e[6:4], e[3:0], 1, 2'b00, m_seq)); end
                    n_cmp++; if (bus.tail !== exp_tail(e[6:4], 1, d, 2'b00)) begin n_fail++; $display("FAIL full_tail%0d: got %h want %h", k, bus.tail, exp_tail(e[6:4], 1, d, 2'b00)); end
                end
                m_seq++;
                release_pkt(1);
            end
        end
        n_cmp++; if (bus.ctx_rd_full !== 1'b0) begin n_fail++; $display("FAIL full_drained: got %b want 0", bus.ctx_rd_full); end
    endtask

    task automatic test_hold_reset;
        bit got;
        logic [6:0] e;
        logic [31:0] d;
        logic [36:0] wh, wt;
        do_reset();
        push_ctx(1, 4'd11, 3'd4);
        push_ctx(0, 4'd1, 3'd1);
        push_ctx(0, 4'd2, 3'd2);
        d = $urandom;
        drive_resp(1, d, 2'b10, got);
        e = q_rd.pop_front();
        wh = exp_header(e[6:4], e[3:0], 1, 2'b10, m_seq);
        wt = exp_tail(e[6:4], 1, d, 2'b10);
        for (int i = 0; i < 6; i++) begin
            n_cmp++; if ({bus.rvalid, bus.header, bus.tail} !== {1'b1, wh, wt}) begin n_fail++; $display("FAIL hold_stable%0d: got %b %h %h want 1 %h %h", i, bus.rvalid, bus.header, bus.tail, wh, wt); end
            tick();
        end
        #2;
        reset_n = 0;
        #1;
        n_cmp++; if ({bus.header, bus.tail} !== 74'd0) begin n_fail++; $display("FAIL hold_reset_flits: got %h %h want 0 0", bus.header, bus.tail); end
        n_cmp++; if ({bus.rvalid, bus.bvalid, bus.s_rready, bus.s_bready} !== 4'b0000) begin n_fail++; $display("FAIL hold_reset_ctrl: got %b want 0000", {bus.rvalid, bus.bvalid, bus.s_rready, bus.s_bready}); end
        @(negedge clock);
        reset_n = 1;
        tick();
        q_rd.delete(); q_wr.delete(); m_seq = 0; m_err = 0;
        bus.s_rvalid = 1; bus.s_bvalid = 1;
        #1;
        n_cmp++; if ({bus.s_rready, bus.s_bready} !== 2'b00) begin n_fail++; $display("FAIL hold_reset_ctx_dropped: got %b want 00", {bus.s_rready, bus.s_bready}); end
        tick();
        n_cmp++; if ({bus.rvalid, bus.bvalid} !== 2'b00) begin n_fail++; $display("FAIL hold_reset_no_capture: got %b want 00", {bus.rvalid, bus.bvalid}); end
        clear_inputs();
    endtask

    task automatic test_random;
        bit got, rd, expect_got;
        logic [6:0] e;
        logic [31:0] d;
        logic [1:0] r;
        do_reset();
        for (int it = 0; it < 80; it++) begin
            rd = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) < 2) begin
                n_cmp++;
                if (rd) begin
                    if (bus.ctx_rd_full !== (q_rd.size() == DEPTH)) begin n_fail++; $display("FAIL rand_rd_full%0d: got %b want %b", it, bus.ctx_rd_full, (q_rd.size() == DEPTH)); end
                end else begin
                    if (bus.ctx_wr_full !== (q_wr.size() == DEPTH)) begin n_fail++; $display("FAIL rand_wr_full%0d: got %b want %b", it, bus.ctx_wr_full, (q_wr.size() == DEPTH)); end
                end
                push_ctx(rd, 4'($urandom), 3'($urandom));
            end else begin
                d = $urandom;
                r = 2'($urandom);
                expect_got = rd ? (q_rd.size() > 0) : (q_wr.size() > 0);
                drive_resp(rd, d, r, got);
                n_cmp++; if (got !== expect_got) begin n_fail++; $display("FAIL rand_accept%0d: got %b want %b", it, got, expect_got); end
                if (got && expect_got) begin
                    e = rd ? q_rd.pop_front() : q_wr.pop_front();
                    n_cmp++; if (bus.header !== exp_header(e[6:4], e[3:0], rd, r, m_seq)) begin n_fail++; $display("FAIL rand_header%0d: got %h want %h", it, bus.header, exp_header(e[6:4], e[3:0], rd, r, m_seq)); end
                    n_cmp++; if (bus.tail !== exp_tail(e[6:4], rd, d, r)) begin n_fail++; $display("FAIL rand_tail%0d: got %h want %h", it, bus.tail, exp_tail(e[6:4], rd, d, r)); end
                    m_seq++;
                    if (r != 2'b00) m_err++;
                end
                if (got) begin
                    repeat ($urandom_range(0, 2)) tick();
                    release_pkt(rd);
                    n_cmp++; if ({bus.rvalid, bus.bvalid} !== 2'b00) begin n_fail++; $display("FAIL rand_release%0d: got %b want 00", it, {bus.rvalid, bus.bvalid}); end
                end
            end
        end
`ifdef SNA_RESP_PKT_ERRCNT_EN
        n_cmp++; if (err_count !== 8'(sat255(m_err))) begin n_fail++; $display("FAIL rand_err_count: got %0d want %0d", err_count, sat255(m_err)); end
`endif
    endtask

`ifdef SNA_RESP_PKT_ERRCNT_EN
    task automatic test_errcnt;
        bit got;
        do_reset();
        n_cmp++; if (err_count !== 8'd0) begin n_fail++; $display("FAIL err_reset: got %0d want 0", err_count); end
        push_ctx(0, 4'd1, 3'd0);
        drive_resp(0, 32'd0, 2'b00, got);
        release_pkt(0);
        n_cmp++; if (err_count !== 8'd0) begin n_fail++; $display("FAIL err_okay_not_counted: got %0d want 0", err_count); end
        for (int i = 0; i < 300; i++) begin
            push_ctx(0, 4'(i), 3'(i));
            drive_resp(0, 32'd0, 2'b10, got);
            if (got) m_err++;
            release_pkt(0);
            if (i == 2) begin
                n_cmp++; if (err_count !== 8'd3) begin n_fail++; $display("FAIL err_three: got %0d want 3", err_count); end
            end
        end
        n_cmp++; if (err_count !== 8'd255) begin n_fail++; $display("FAIL err_saturate: got %0d want 255", err_count); end
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_inputs();
        test_reset();
        test_read_basic();
        test_b_stall();
        test_priority();
        test_full();
        test_hold_reset();
        test_random();
`ifdef SNA_RESP_PKT_ERRCNT_EN
        test_errcnt();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
